prt_scaler_slw_ctl: RTL

- Sequencer for the scaler sliding-window tap mux: a 7-tap window (taps A..G) holds consecutive source pixels of one line, and the mux registers one selected tap onto its output.
- Per line, this block fills the window, then runs a fixed-point phase accumulator. It chooses between window shifts (source pixel consumed) and output writes (SEL/WR to the mux), and produces the aligned output valid/last flags.
- Sits between the line buffer read side and the mux, one instance per scaling direction.

---
 rtl/prt_scaler_pkg.sv | 28 ++
 rtl/prt_scaler_slw_ctl_if.sv | 28 ++
 rtl/prt_scaler_slw_ctl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/prt_scaler_pkg.sv
// +----------------------------------------------------------------------------+
// | prt_scaler_pkg                                                             |
// | Shared types and constants for the scaler sliding-window sequencer.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package prt_scaler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } slw_state_e;

  localparam int P_SLW_TAPS    = 7;
  localparam int P_SLW_SEL_MAX = 6;

  // Integer part of the accumulator can exceed the last tap index.
  function automatic logic [2:0] slw_sel_clamp(input logic [3:0] acc_int);
    if (acc_int > 4'(P_SLW_SEL_MAX)) return 3'(P_SLW_SEL_MAX);
    return acc_int[2:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/prt_scaler_slw_ctl_if.sv
// +----------------------------------------------------------------------------+
// | prt_scaler_slw_ctl_if                                                      |
// | Window-shift and tap-mux handshake bundle of the sliding-window sequencer. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface prt_scaler_slw_ctl_if;
  logic       SRC_RDY_IN;
  logic       SHIFT_OUT;
  logic       DST_RDY_IN;
  logic [2:0] SEL_OUT;
  logic       WR_OUT;
  logic       VLD_OUT;
  logic       LAST_OUT;

  modport master (
    input  SRC_RDY_IN, DST_RDY_IN,
    output SHIFT_OUT, SEL_OUT, WR_OUT, VLD_OUT, LAST_OUT
  );

  modport slave (
    output SRC_RDY_IN, DST_RDY_IN,
    input  SHIFT_OUT, SEL_OUT, WR_OUT, VLD_OUT, LAST_OUT
  );
endinterface

`default_nettype wire

// File: rtl/prt_scaler_slw_ctl.sv
// +----------------------------------------------------------------------------+
// | prt_scaler_slw_ctl                                                         |
// | Per-line window fill plus phase accumulator choosing shift vs. mux write.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module prt_scaler_slw_ctl
  import prt_scaler_pkg::*;
#(
  parameter int P_FRAC  = 16,
  parameter int P_LEN_W = 13,
  parameter int P_TH    = 4
) (
  input  logic                CLK_IN,
  input  logic                RST_IN,
  input  logic [P_FRAC+1:0]   CFG_STEP_IN,
  input  logic [P_LEN_W-1:0]  CFG_IN_LEN_IN,
  input  logic [P_LEN_W-1:0]  CFG_OUT_LEN_IN,
  input  logic                LINE_START_IN,
  output logic                BUSY_OUT,
  output logic                DONE_OUT,
  prt_scaler_slw_ctl_if.master slw
);

  localparam int                 ACC_W      = P_FRAC + 4;
  localparam logic [ACC_W-1:0]   C_ACC_ONE  = ACC_W'(1) << P_FRAC;
  localparam logic [P_LEN_W-1:0] C_TAPS     = P_LEN_W'(P_SLW_TAPS);
  localparam logic [2:0]         C_FILL_END = 3'(P_SLW_TAPS - 1);
  localparam logic [3:0]         C_TH       = 4'(P_TH);

  slw_state_e           state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [P_FRAC+1:0]    step_q, step_d;
  logic [P_LEN_W-1:0]   src_rem_q, src_rem_d;
  logic [P_LEN_W-1:0]   out_last_q, out_last_d;
  logic [P_LEN_W-1:0]   out_cnt_q, out_cnt_d;
  logic [2:0]           fill_cnt_q, fill_cnt_d;
  logic                 vld_q, last_q, done_q, busy_q;

  logic [3:0]           w_acc_int;
  logic [ACC_W:0]       w_acc_sum;
  logic                 w_shift_pend;
  logic                 w_shift;
  logic                 w_wr;
  logic                 w_last_wr;

  assign w_acc_int    = acc_q[ACC_W-1 -: 4];
  assign w_acc_sum    = {1'b0, acc_q} + {{(ACC_W-P_FRAC-1){1'b0}}, step_q};
  // A pending shift owns the cycle even while the source stalls.
  assign w_shift_pend = (state_q == ST_RUN) && (w_acc_int >= C_TH) && (src_rem_q != '0);
  assign w_shift      = ((state_q == ST_FILL) || w_shift_pend) && slw.SRC_RDY_IN;
  assign w_wr         = (state_q == ST_RUN) && !w_shift_pend && slw.DST_RDY_IN;
  assign w_last_wr    = (out_cnt_q == out_last_q);

  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      step_q     <= '0;
      src_rem_q  <= '0;
      out_last_q <= '0;
      out_cnt_q  <= '0;
      fill_cnt_q <= '0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      step_q     <= step_d;
      src_rem_q  <= src_rem_d;
      out_last_q <= out_last_d;
      out_cnt_q  <= out_cnt_d;
      fill_cnt_q <= fill_cnt_d;
      vld_q      <= w_wr;
      last_q     <= w_wr && w_last_wr;
      done_q     <= (state_q == ST_DONE);
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    step_d     = step_q;
    src_rem_d  = src_rem_q;
    out_last_d = out_last_q;
    out_cnt_d  = out_cnt_q;
    fill_cnt_d = fill_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (LINE_START_IN) begin
          step_d     = (CFG_STEP_IN == '0) ? {{(P_FRAC+1){1'b0}}, 1'b1} : CFG_STEP_IN;
          src_rem_d  = (CFG_IN_LEN_IN > C_TAPS) ? CFG_IN_LEN_IN - C_TAPS : '0;
          out_last_d = (CFG_OUT_LEN_IN == '0) ? '0 : CFG_OUT_LEN_IN - 1'b1;
          acc_d      = '0;
          out_cnt_d  = '0;
          fill_cnt_d = '0;
          state_d    = ST_FILL;
        end
      end
      ST_FILL: begin
        if (w_shift) begin
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_q == C_FILL_END) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_shift) begin
          acc_d     = acc_q - C_ACC_ONE;
          src_rem_d = src_rem_q - 1'b1;
        end else if (w_wr) begin
          acc_d     = w_acc_sum[ACC_W] ? '1 : w_acc_sum[ACC_W-1:0];
          out_cnt_d = out_cnt_q + 1'b1;
          if (w_last_wr) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    slw.SHIFT_OUT = w_shift;
    slw.WR_OUT    = w_wr;
    slw.SEL_OUT   = (state_q == ST_RUN) ? slw_sel_clamp(w_acc_int) : 3'd0;
    slw.VLD_OUT   = vld_q;
    slw.LAST_OUT  = last_q;
    BUSY_OUT      = busy_q;
    DONE_OUT      = done_q;
  end

endmodule

`default_nettype wire
